branch_pred_ctrl: RTL and testbench
===================================

Name: branch_pred_ctrl

Overview:
- Branch control unit for the pipelined core.
- Predicts conditional branches at fetch using a 2-bit saturating-counter branch history table (BHT).
- Resolves predictions against the branch-condition unit's taken output at execute, and sequences redirect/flush on misprediction.
- Keeps branch and mispredict statistics.

Parameters:
- IDX_W, 6, BHT index width; 2**IDX_W entries, indexed by PC[IDX_W+1:2].
- FLUSH_CYC, 2, cycles flush is held after a mispredict; legal range 1..15.
- XLEN, 32, address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- f_pc  in  XLEN  fetch-stage PC.
- f_is_branch  in  1  fetch instruction is a conditional branch.
- f_imm  in  XLEN  sign-extended B-type offset of the fetch instruction.
- pred_taken  out  1  prediction for the fetch instruction (combinational).
- pred_target  out  XLEN  f_pc + f_imm (combinational).
- r_valid  in  1  a branch is resolving at execute this cycle.
- r_pc  in  XLEN  PC of the resolving branch.
- r_target  in  XLEN  computed target of the resolving branch.
- r_pred  in  1  prediction carried down the pipe with that branch.
- r_taken  in  1  actual outcome from the branch-condition unit.
- redirect  out  1  one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  out  XLEN  corrected fetch address.
- flush  out  1  kill younger in-flight instructions.
- br_count  out  16  resolved branches, saturating.
- mispred_count  out  16  mispredicts, saturating.

Behaviour:
- Reset (async, rst=1):
  - All BHT entries = 2'b01 (weakly not-taken).
  - FSM = RUN.
  - redirect=0, redirect_pc=0, flush=0, br_count=0, mispred_count=0.
  - Takes effect immediately, including mid-flush.
- Prediction (combinational):
  - pred_taken = f_is_branch & BHT[f_pc[IDX_W+1:2]][1].
  - pred_target = f_pc + f_imm, modulo 2**XLEN.
  - No write-to-read bypass: a same-cycle update to the same index is not visible until the next cycle.
- Resolve, sampled at a rising edge in state RUN with r_valid=1:
  - BHT entry at r_pc[IDX_W+1:2] updates: r_taken increments, else decrements. Saturates at 2'b11 and 2'b00.
  - br_count increments, holding at 16'hFFFF.
  - mispredict = (r_taken != r_pred).
- On mispredict:
  - mispred_count increments (saturating).
  - redirect_pc is registered as r_taken ? r_target : r_pc + 4.
  - FSM -> FLUSH, with the flush counter loaded to FLUSH_CYC-1.
- FSM:
  - RUN: flush=0, redirect=0.
  - FLUSH, first cycle: redirect=1, flush=1.
  - FLUSH, subsequent cycles: redirect=0, flush=1.
  - In FLUSH the counter decrements each cycle. When it reaches 0, the next state is RUN.
  - Total flush high time = exactly FLUSH_CYC cycles. Redirect is high for exactly 1 cycle, aligned with the first flush cycle.
  - Latency: mispredict sampled at edge N -> redirect/flush high during cycle N+1.
- Wrong-path suppression: while in FLUSH, r_valid is ignored. No BHT update, no counter change, no new mispredict.
- redirect_pc holds its value until the next mispredict.
- Aliasing: distinct PCs sharing an index share an entry. No tags.

Decomposition:
- Shared package branch_pkg holds:
  - FSM state encoding: RUN, FLUSH.
  - Counter encodings: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - BHT_RESET=WNT.
  - Counter max constant 16'hFFFF.
- One natural sub-module, sat_ctr2: combinational next-state of a 2-bit saturating counter from (cur, taken).
- BHT array, FSM and statistics counters stay in branch_pred_ctrl.

Test Plan:
- Reset: assert rst mid-operation -> all outputs 0 immediately. Then f_is_branch=1, f_pc=0x100 -> pred_taken=0 and pred_target=f_pc+f_imm, e.g. f_imm=0x20 gives 0x120.
- Training at r_pc=0x100, r_pred=0:
  - Resolve taken once -> mispredict; redirect pulses next cycle with redirect_pc=r_target (0x140); flush high 2 cycles.
  - After FLUSH, resolve taken again -> entry=ST; f_pc=0x100 then gives pred_taken=1.
  - Same-index read/write in one cycle returns the old prediction.
- Not-taken mispredict: r_pc=0x200, r_pred=1, r_taken=0 -> redirect_pc=0x204; mispred_count+1; br_count+1.
- Wrong-path suppression: r_valid=1 with a mismatching outcome during both FLUSH cycles -> no BHT change, counters unchanged, no second redirect.
- Saturation and wrap:
  - 4 taken resolves at one PC -> entry stays 2'b11, and one not-taken -> 2'b10.
  - f_pc=0xFFFFFFF0, f_imm=0x20 -> pred_target=0x00000010.
  - Drive br_count to 0xFFFF -> holds.
- Reset mid-flush: assert rst in the first FLUSH cycle -> flush, redirect drop at once; after release, FSM is RUN and BHT is back to WNT.

Source files
------------

// File: rtl/branch_pred_ctrl_pkg.sv
// Shared types and constants for the branch control unit: FSM states,
// 2-bit BHT counter encodings and the saturating statistics helper.
package branch_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam logic [1:0]  BHT_RESET = WNT;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        sat_inc16 = (val == CNT_MAX) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/branch_pred_ctrl_if.sv
// Fetch-side prediction, execute-side resolve and redirect/statistics bundle.
interface branch_pred_ctrl_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] f_pc;
    logic            f_is_branch;
    logic [XLEN-1:0] f_imm;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_target;
    logic            r_pred;
    logic            r_taken;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
    logic [15:0]     br_count;
    logic [15:0]     mispred_count;

    modport master (
        output f_pc, f_is_branch, f_imm, r_valid, r_pc, r_target, r_pred, r_taken,
        input  pred_taken, pred_target, redirect, redirect_pc, flush, br_count, mispred_count
    );

    modport slave (
        input  f_pc, f_is_branch, f_imm, r_valid, r_pc, r_target, r_pred, r_taken,
        output pred_taken, pred_target, redirect, redirect_pc, flush, br_count, mispred_count
    );
endinterface

// File: rtl/branch_pred_ctrl_sat_ctr2.sv
// Next-state logic of a 2-bit saturating branch counter.
module sat_ctr2
    import branch_pkg::*;
(
    input  logic [1:0] i_cur,
    input  logic       i_taken,
    output logic [1:0] o_next
);

    // Step toward ST on taken, toward SNT on not-taken, clamping at the ends.
    always_comb begin
        o_next = i_cur;
        if (i_taken) begin
            if (i_cur != ST) begin
                o_next = i_cur + 2'b01;
            end else begin
                o_next = i_cur;
            end
        end else begin
            if (i_cur != SNT) begin
                o_next = i_cur - 2'b01;
            end else begin
                o_next = i_cur;
            end
        end
    end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch control unit: BHT prediction at fetch, resolve at execute,
// redirect/flush sequencing on mispredict, and branch statistics.
module branch_pred_ctrl
    import branch_pkg::*;
#(
    parameter int IDX_W     = 6,
    parameter int FLUSH_CYC = 2,
    parameter int XLEN      = 32
) (
    input  logic               clk,
    input  logic               rst,
    branch_pred_ctrl_if.slave  bus
);

    localparam int         ENTRIES    = 1 << IDX_W;
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYC - 1);

    logic [1:0]      r_bht [ENTRIES];
    state_t          r_state;
    logic [3:0]      r_flush_ctr;
    logic            r_redirect;
    logic            r_flush;
    logic [XLEN-1:0] r_redirect_pc;
    logic [15:0]     r_br_count;
    logic [15:0]     r_mispred_count;

    logic [IDX_W-1:0] w_f_idx;
    logic [IDX_W-1:0] w_r_idx;
    logic [1:0]       w_upd_next;
    logic             w_mispredict;

    assign w_f_idx      = bus.f_pc[IDX_W+1:2];
    assign w_r_idx      = bus.r_pc[IDX_W+1:2];
    assign w_mispredict = bus.r_taken ^ bus.r_pred;

    sat_ctr2 u_sat_ctr2 (
        .i_cur   (r_bht[w_r_idx]),
        .i_taken (bus.r_taken),
        .o_next  (w_upd_next)
    );

    // Reads the pre-update table, so a same-cycle write is not bypassed.
    assign bus.pred_taken    = bus.f_is_branch & r_bht[w_f_idx][1];
    assign bus.pred_target   = bus.f_pc + bus.f_imm;
    assign bus.redirect      = r_redirect;
    assign bus.redirect_pc   = r_redirect_pc;
    assign bus.flush         = r_flush;
    assign bus.br_count      = r_br_count;
    assign bus.mispred_count = r_mispred_count;

    // BHT, resolve FSM, redirect/flush outputs and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_bht[i] <= BHT_RESET;
            end
            r_state         <= RUN;
            r_flush_ctr     <= 4'd0;
            r_redirect      <= 1'b0;
            r_flush         <= 1'b0;
            r_redirect_pc   <= '0;
            r_br_count      <= 16'd0;
            r_mispred_count <= 16'd0;
        end else begin
            case (r_state)
                RUN: begin
                    r_redirect <= 1'b0;
                    r_flush    <= 1'b0;
                    if (bus.r_valid) begin
                        r_bht[w_r_idx] <= w_upd_next;
                        r_br_count     <= sat_inc16(r_br_count);
                        if (w_mispredict) begin
                            r_mispred_count <= sat_inc16(r_mispred_count);
                            r_redirect_pc   <= bus.r_taken ? bus.r_target
                                                           : bus.r_pc + XLEN'(4);
                            r_flush_ctr     <= FLUSH_INIT;
                            r_state         <= FLUSH;
                            r_redirect      <= 1'b1;
                            r_flush         <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    // Wrong-path resolves are ignored here entirely.
                    r_redirect <= 1'b0;
                    if (r_flush_ctr == 4'd0) begin
                        r_state <= RUN;
                        r_flush <= 1'b0;
                    end else begin
                        r_flush_ctr <= r_flush_ctr - 4'd1;
                        r_flush     <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= RUN;
                    r_redirect <= 1'b0;
                    r_flush    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed bench for branch_pred_ctrl with a per-cycle behavioural model.
module tb_branch_pred_ctrl;

    localparam int IDX_W     = 6;
    localparam int FLUSH_CYC = 2;
    localparam int XLEN      = 32;
    localparam int ENTRIES   = 1 << IDX_W;

    logic clk;
    logic rst;

    branch_pred_ctrl_if #(.XLEN(XLEN)) bus ();

    branch_pred_ctrl #(
        .IDX_W     (IDX_W),
        .FLUSH_CYC (FLUSH_CYC),
        .XLEN      (XLEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: counters as plain integers 0..3, flush as cycles remaining.
    int          m_bht [ENTRIES];
    int          m_br;
    int          m_mis;
    int          m_flush_left;
    bit          m_redirect;
    logic [31:0] m_rpc;

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_bht[i] = 1;
        m_br = 0; m_mis = 0; m_flush_left = 0; m_redirect = 0; m_rpc = 32'd0;
    endtask

    initial model_reset();

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else if (m_flush_left > 0) begin
            m_redirect   = 0;
            m_flush_left = m_flush_left - 1;
        end else begin
            m_redirect = 0;
            if (bus.r_valid) begin
                int idx;
                idx = (bus.r_pc >> 2) % ENTRIES;
                if (bus.r_taken) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
                else             m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
                if (m_br < 65535) m_br = m_br + 1;
                if (bus.r_taken != bus.r_pred) begin
                    if (m_mis < 65535) m_mis = m_mis + 1;
                    m_rpc        = bus.r_taken ? bus.r_target : bus.r_pc + 32'd4;
                    m_redirect   = 1;
                    m_flush_left = FLUSH_CYC;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        int fidx;
        fidx = (bus.f_pc >> 2) % ENTRIES;
        chk("pred_taken",    32'(bus.pred_taken),  32'(bus.f_is_branch && (m_bht[fidx] >= 2)));
        chk("pred_target",   bus.pred_target,      bus.f_pc + bus.f_imm);
        chk("redirect",      32'(bus.redirect),    32'(m_redirect));
        chk("flush",         32'(bus.flush),       32'(m_flush_left > 0));
        chk("redirect_pc",   bus.redirect_pc,      m_rpc);
        chk("br_count",      32'(bus.br_count),    32'(m_br));
        chk("mispred_count", 32'(bus.mispred_count), 32'(m_mis));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] imm);
        bus.f_is_branch = 1'b1; bus.f_pc = pc; bus.f_imm = imm;
    endtask

    task automatic resolve(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                           input logic pred, input logic taken);
        bus.r_valid = v; bus.r_pc = pc; bus.r_target = tgt; bus.r_pred = pred; bus.r_taken = taken;
    endtask

    // Issue one resolve, then idle through any flush it triggers.
    task automatic one_resolve(input logic [31:0] pc, input logic [31:0] tgt,
                               input logic pred, input logic taken);
        step(); resolve(1'b1, pc, tgt, pred, taken);
        step(); resolve(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (FLUSH_CYC + 1) step();
    endtask

    initial begin
        rst = 1'b1;
        bus.f_is_branch = 1'b0; bus.f_pc = 32'd0; bus.f_imm = 32'd0;
        resolve(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Prediction after reset: weakly not-taken, target is pc+imm.
        fetch(32'h100, 32'h20);
        @(negedge clk);
        chk("lit_reset_pred",   32'(bus.pred_taken), 32'd0);
        chk("lit_reset_target", bus.pred_target,     32'h120);
        chk("lit_reset_brcnt",  32'(bus.br_count),   32'd0);

        // Taken mispredict at 0x100; fetch same index to see the old prediction.
        step(); resolve(1'b1, 32'h100, 32'h140, 1'b0, 1'b1);
        @(negedge clk);
        chk("lit_same_cycle_pred", 32'(bus.pred_taken), 32'd0);
        step(); resolve(1'b1, 32'h300, 32'h999, 1'b1, 1'b0);
        @(negedge clk);
        chk("lit_redirect",    32'(bus.redirect), 32'd1);
        chk("lit_flush1",      32'(bus.flush),    32'd1);
        chk("lit_redirect_pc", bus.redirect_pc,   32'h140);
        step();
        @(negedge clk);
        chk("lit_redirect_once", 32'(bus.redirect), 32'd0);
        chk("lit_flush2",        32'(bus.flush),    32'd1);
        step(); resolve(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("lit_flush_done", 32'(bus.flush),         32'd0);
        chk("lit_br_wrong",   32'(bus.br_count),      32'd1);
        chk("lit_mis_wrong",  32'(bus.mispred_count), 32'd1);
        chk("lit_wt_pred",    32'(bus.pred_taken),    32'd1);

        // Saturate at ST, then two not-taken steps back to WNT.
        repeat (5) one_resolve(32'h100, 32'h140, 1'b1, 1'b1);
        @(negedge clk);
        chk("lit_st_pred",  32'(bus.pred_taken), 32'd1);
        one_resolve(32'h100, 32'h140, 1'b1, 1'b0);
        @(negedge clk);
        chk("lit_nt_rpc",   bus.redirect_pc,      32'h104);
        chk("lit_wt_again", 32'(bus.pred_taken),  32'd1);
        one_resolve(32'h100, 32'h140, 1'b1, 1'b0);
        @(negedge clk);
        chk("lit_wnt_pred", 32'(bus.pred_taken),  32'd0);

        // Not-taken mispredict at 0x200 (aliases with 0x100).
        one_resolve(32'h200, 32'h280, 1'b1, 1'b0);
        @(negedge clk);
        chk("lit_rpc_204", bus.redirect_pc,         32'h204);
        chk("lit_br_9",    32'(bus.br_count),       32'd9);
        chk("lit_mis_4",   32'(bus.mispred_count),  32'd4);

        // Address wrap of the prediction target.
        fetch(32'hFFFF_FFF0, 32'h20);
        @(negedge clk);
        chk("lit_wrap", bus.pred_target, 32'h10);

        // Train 0x180 to taken, then reset in the first cycle of a flush.
        fetch(32'h180, 32'h8);
        one_resolve(32'h180, 32'h188, 1'b0, 1'b1);
        one_resolve(32'h180, 32'h188, 1'b1, 1'b1);
        step(); resolve(1'b1, 32'h180, 32'h188, 1'b1, 1'b0);
        step(); resolve(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("lit_pre_rst_flush", 32'(bus.flush), 32'd1);
        rst = 1'b1;
        #1;
        chk("lit_rst_flush",    32'(bus.flush),         32'd0);
        chk("lit_rst_redirect", 32'(bus.redirect),      32'd0);
        chk("lit_rst_rpc",      bus.redirect_pc,        32'd0);
        chk("lit_rst_mis",      32'(bus.mispred_count), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("lit_rst_bht", 32'(bus.pred_taken), 32'd0);
        chk("lit_rst_run", 32'(bus.flush),      32'd0);

        // Drive br_count to saturation with correct predictions.
        step(); resolve(1'b1, 32'h40, 32'h80, 1'b0, 1'b0);
        repeat (65540) step();
        resolve(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("lit_br_sat",  32'(bus.br_count),      32'hFFFF);
        chk("lit_mis_sat", 32'(bus.mispred_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
